// File: rtl/multi_edge_detector.sv
// Multi-channel synchronised edge detector with per-channel mode, saturating event
// counters behind a muxed read port, and an optional sticky pending/IRQ bank (EDGE_STICKY_EN).
module multi_edge_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     D,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [SEL_W-1:0]     cnt_sel,
    input  logic                 cnt_clr,
    input  logic [WIDTH-1:0]     pend_clr,
    output logic [WIDTH-1:0]     detect,
    output logic [CNT_W-1:0]     edge_cnt,
    output logic                 cnt_sat,
    output logic [WIDTH-1:0]     pend,
    output logic                 irq
);
    logic [WIDTH-1:0][CNT_W-1:0] cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        med_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .d    (D[i]),
            .mode (mode[2*i +: 2]),
            .clr  (cnt_clr && (cnt_sel == SEL_W'(i))),
            .det  (detect[i]),
            .cnt  (cnt[i])
        );
    end

    // Out-of-range selects match no lane, so they read as zero and clear nothing.
    always_comb begin
        edge_cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            if (cnt_sel == SEL_W'(i)) edge_cnt = cnt[i];
        cnt_sat = (edge_cnt == {CNT_W{1'b1}}) && (cnt_sel < SEL_W'(WIDTH) || WIDTH >= (1 << SEL_W));
    end

`ifdef EDGE_STICKY_EN
    // A same-cycle detect wins over the write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= detect | (pend & ~pend_clr);
            irq  <= |pend;
        end
    end
`else
    wire unused_pend_clr = &{1'b0, pend_clr};
    assign pend = '0;
    assign irq  = 1'b0;
`endif

endmodule

// One channel: synchroniser, edge classification, registered pulse and saturating counter.
module med_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             det,
    output logic [CNT_W-1:0] cnt
);
    logic [SYNC_STAGES-1:0] s;
    logic                   prev;
    logic                   rise, fall, hit;

    always_comb begin
        rise = s[SYNC_STAGES-1] & ~prev;
        fall = ~s[SYNC_STAGES-1] & prev;
        unique case (mode)
            2'b01:   hit = rise;
            2'b10:   hit = fall;
            2'b11:   hit = rise | fall;
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            prev <= 1'b0;
            det  <= 1'b0;
            cnt  <= '0;
        end else begin
            s[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) s[k] <= s[k-1];
            prev <= s[SYNC_STAGES-1];
            det  <= hit;
            // Clear coinciding with a counted pulse keeps that pulse.
            if (clr)
                cnt <= CNT_W'(det);
            else if (det && cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: expected detect pulses are queued when D is driven
// and checked every cycle; counters, select, sticky bank and async reset checked at fixed points.
module tb_multi_edge_detector;
    localparam int W  = 6;
    localparam int SS = 2;
    localparam int CW = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  D = '0;
    logic [2*W-1:0] mode = '0;
    logic [SW-1:0] cnt_sel = '0;
    logic          cnt_clr = 1'b0;
    logic [W-1:0]  pend_clr = '0;
    logic [W-1:0]  detect;
    logic [CW-1:0] edge_cnt;
    logic          cnt_sat;
    logic [W-1:0]  pend;
    logic          irq;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .D(D), .mode(mode), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
        .pend_clr(pend_clr), .detect(detect), .edge_cnt(edge_cnt), .cnt_sat(cnt_sat),
        .pend(pend), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [W-1:0] det; } exp_t;
    exp_t         q[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           mon_on = 1'b0;
    logic [W-1:0] dprev = '0;
    logic [W-1:0] mon_e;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive D and queue the pulse the edge should produce 3 edges later (2 sync + detect reg).
    task automatic drive(input logic [W-1:0] nd);
        logic [W-1:0] r, f, e;
        r = nd & ~dprev;
        f = ~nd & dprev;
        e = '0;
        for (int i = 0; i < W; i++)
            case (mode[2*i +: 2])
                2'b01:   e[i] = r[i];
                2'b10:   e[i] = f[i];
                2'b11:   e[i] = r[i] | f[i];
                default: e[i] = 1'b0;
            endcase
        if (e != '0) begin
            if (q.size() > 0 && q[q.size()-1].cyc == cyc + SS + 1)
                q[q.size()-1].det = q[q.size()-1].det | e;
            else
                q.push_back('{cyc + SS + 1, e});
        end
        dprev = nd;
        D     = nd;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_e = '0;
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                if (q[0].cyc < cyc) chk("stale_expect", 32'(q[0].cyc), 32'(cyc));
                mon_e = q[0].det;
                void'(q.pop_front());
            end
            chk("detect", 32'(detect), 32'(mon_e));
`ifndef EDGE_STICKY_EN
            chk("pend_off", 32'(pend), 32'h0);
            chk("irq_off", 32'(irq), 32'h0);
`endif
        end
    end

    initial begin
        // reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_detect", 32'(detect), 0);
        chk("rst_cnt", 32'(edge_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_irq", 32'(irq), 0);
        mon_on = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);

        // latency: ch0 rise only
        mode = 12'b00_00_00_00_00_01;
        step(2);
        drive(6'h01);
        step(5);
        drive(6'h00);
        step(5);

        // modes: ch1 fall, ch2 both, ch3 off, ch5 rise
        mode = 12'b01_00_00_11_10_01;
        step(2);
        drive(6'h0E);
        step(4);
        drive(6'h00);
        step(6);

        // counter: clear, 20 rises on ch0 saturates at 15
        cnt_sel = 3'd0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_first", 32'(edge_cnt), 0);
        for (int i = 0; i < 40; i++) begin
            drive(dprev ^ 6'h01);
            step();
        end
        step(5);
        chk("sat_cnt", 32'(edge_cnt), 15);
        chk("sat_flag", 32'(cnt_sat), 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_idle", 32'(edge_cnt), 0);
        chk("clr_idle_sat", 32'(cnt_sat), 0);
        drive(6'h01);
        step(SS + 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_coincident", 32'(edge_cnt), 1);
        drive(6'h00);
        step(5);
        chk("after_fall", 32'(edge_cnt), 1);

        // bad select clears nothing and reads zero
        cnt_sel = 3'd6;
        cnt_clr = 1'b1;
        #1;
        chk("badsel_cnt", 32'(edge_cnt), 0);
        chk("badsel_sat", 32'(cnt_sat), 0);
        step();
        cnt_clr = 1'b0;
        cnt_sel = 3'd0; #1 chk("keep_ch0", 32'(edge_cnt), 1);
        cnt_sel = 3'd1; #1 chk("keep_ch1", 32'(edge_cnt), 1);
        cnt_sel = 3'd2; #1 chk("keep_ch2", 32'(edge_cnt), 2);
        cnt_sel = 3'd3; #1 chk("keep_ch3", 32'(edge_cnt), 0);
        step();

        // sticky pending on ch5
        drive(6'h20);
        step(SS + 2);
`ifdef EDGE_STICKY_EN
        chk("pend_set", 32'(pend), 32'h20);
        chk("irq_lag", 32'(irq), 0);
        step();
        chk("irq_set", 32'(irq), 1);
`else
        chk("pend_off_set", 32'(pend), 0);
        step();
        chk("irq_off_set", 32'(irq), 0);
`endif
        drive(6'h00);
        step(3);
        drive(6'h20);
        step(SS + 1);
        pend_clr = 6'h20;
        step();
        pend_clr = 6'h00;
`ifdef EDGE_STICKY_EN
        chk("pend_set_wins", 32'(pend), 32'h20);
`else
        chk("pend_off_wins", 32'(pend), 0);
`endif
        step(2);
        pend_clr = 6'h20;
        step();
        pend_clr = 6'h00;
        chk("pend_cleared", 32'(pend), 0);
        step();
        chk("irq_cleared", 32'(irq), 0);
        cnt_sel = 3'd5;
        #1 chk("ch5_cnt", 32'(edge_cnt), 2);

        // async reset mid-run with edges in flight
        mode = 12'hFFF;
        step(2);
        drive(6'h3F);
        step();
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("arst_detect", 32'(detect), 0);
        chk("arst_cnt", 32'(edge_cnt), 0);
        chk("arst_pend", 32'(pend), 0);
        chk("arst_irq", 32'(irq), 0);
        step(3);
        rst = 1'b0;
        dprev = '0;
        drive(6'h3F);
        step(6);
        chk("post_rst_ch5", 32'(edge_cnt), 1);
        cnt_sel = 3'd0;
        #1 chk("post_rst_ch0", 32'(edge_cnt), 1);
        step(2);
        chk("queue_drained", 32'(q.size()), 0);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
